// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBB  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_SHLN = 4'b1100;
  localparam logic [3:0] OP_SHRN = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_CMP  = 4'b1111;

  // Bit positions inside the {Z,C,N,V} flag vector.
  localparam int unsigned FZ = 3;
  localparam int unsigned FC = 2;
  localparam int unsigned FN = 1;
  localparam int unsigned FV = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Opcodes that run through the iterative datapath instead of alu_core.
  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake between the control unit and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       alus;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] bus;
  logic             cin;
  logic [WIDTH-1:0] dout;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (output start, alus, x, bus, cin,
                  input  dout, flags, busy, done);
  modport slave  (input  start, alus, x, bus, cin,
                  output dout, flags, busy, done);
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations and {Z,C,N,V} flag generation.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       alus,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] bus,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             c;
  logic             v;

  // Add/subtract share one W+1-bit path; bit W is carry-out or borrow.
  always_comb begin
    wide = '0;
    y    = bus;
    ci   = 1'b0;
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (alus)
      OP_ADD, OP_ADC, OP_INC: begin
        y    = (alus == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus;
        ci   = (alus == OP_ADC) ? cin : 1'b0;
        wide = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (x[MSB] == y[MSB]) && (res[MSB] != x[MSB]);
      end
      OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
        y    = (alus == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus;
        ci   = (alus == OP_SBB) ? cin : 1'b0;
        wide = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (x[MSB] != y[MSB]) && (res[MSB] != x[MSB]);
      end
      OP_AND: res = x & bus;
      OP_OR:  res = x | bus;
      OP_XOR: res = x ^ bus;
      OP_NOT: res = ~x;
      OP_SHL: begin
        res = {x[WIDTH-2:0], 1'b0};
        c   = x[MSB];
      end
      OP_SHR: begin
        res = {1'b0, x[WIDTH-1:1]};
        c   = x[0];
      end
      default: res = '0;
    endcase
    flags     = '0;
    flags[FZ] = (res == '0);
    flags[FC] = c;
    flags[FN] = res[MSB];
    flags[FV] = v;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops via alu_core, iterative shifts and
// shift-add multiply via a small IDLE/ITER/FIN sequencer.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   io
);

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               c_q, c_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [3:0]         flags_q, flags_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   core_res;
  logic [3:0]         core_flags;
  logic [CNT_W-1:0]   n_raw;
  logic [CNT_W-1:0]   n_clamp;
  logic [WIDTH-1:0]   fin_res;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alus  (io.alus),
    .x     (io.x),
    .bus   (io.bus),
    .cin   (io.cin),
    .res   (core_res),
    .flags (core_flags)
  );

  assign n_raw   = io.bus[CNT_W-1:0];
  assign n_clamp = (n_raw > W_CNT) ? W_CNT : n_raw;

  // Next-state logic; a_q doubles as shift register and as the multiplicand,
  // which is why it is 2*WIDTH wide while shifts only use the low half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    op_d    = op_q;
    dout_d  = dout_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    fin_res = (op_q == OP_MUL) ? acc_q[WIDTH-1:0] : a_q[WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (io.start) begin
          if (is_multi(io.alus)) begin
            op_d  = io.alus;
            a_d   = {{WIDTH{1'b0}}, io.x};
            b_d   = io.bus;
            acc_d = '0;
            c_d   = 1'b0;
            if (io.alus == OP_MUL) begin
              cnt_d   = W_CNT;
              state_d = ITER;
            end else begin
              cnt_d   = n_clamp;
              state_d = (n_clamp == '0) ? FIN : ITER;
            end
          end else begin
            if (io.alus != OP_CMP) dout_d = core_res;
            flags_d = core_flags;
            done_d  = 1'b1;
          end
        end
      end
      ITER: begin
        case (op_q)
          OP_SHLN: begin
            c_d = a_q[WIDTH-1];
            a_d = a_q << 1;
          end
          OP_SHRN: begin
            c_d = a_q[0];
            a_d = a_q >> 1;
          end
          default: begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        dout_d     = fin_res;
        flags_d    = '0;
        flags_d[FZ] = (fin_res == '0);
        flags_d[FC] = (op_q == OP_MUL) ? |acc_q[2*WIDTH-1:WIDTH] : c_q;
        flags_d[FN] = fin_res[WIDTH-1];
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      op_q    <= '0;
      dout_q  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.dout  = dout_q;
  assign io.flags = flags_q;
  assign io.busy  = busy_q;
  assign io.done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) with an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int prev_dout = 0;

  alu_seq_if #(.WIDTH(8)) aif ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (aif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: result, {Z,C,N,V} flags and edges-until-done from plain arithmetic.
  function automatic void model(input int op, input int x, input int b, input int ci,
                                input int prev, output int r_o, output int fl_o,
                                output int cyc);
    int r, c, v, s, m;
    r = 0; c = 0; v = 0; cyc = 1;
    m = b % 16;
    if (m > 8) m = 8;
    case (op)
      0, 1, 8: begin
        int y, k;
        y = (op == 1) ? 1 : b;
        k = (op == 8) ? ci : 0;
        r = x + y + k;
        c = (r > 255) ? 1 : 0;
        s = sgn8(x) + sgn8(y) + k;
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      2, 3, 9, 15: begin
        int y, k;
        y = (op == 3) ? 1 : b;
        k = (op == 9) ? ci : 0;
        r = x - y - k;
        c = (r < 0) ? 1 : 0;
        s = sgn8(x) - sgn8(y) - k;
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      4: r = x & b;
      5: r = x | b;
      6: r = 255 - x;
      7: begin r = x * 2; c = (r > 255) ? 1 : 0; end
      10: r = x ^ b;
      11: begin r = x / 2; c = x % 2; end
      12: begin
        r = x << m;
        c = (m == 0) ? 0 : (x >> (8 - m)) & 1;
        cyc = m + 2;
      end
      13: begin
        r = x >> m;
        c = (m == 0) ? 0 : (x >> (m - 1)) & 1;
        cyc = m + 2;
      end
      default: begin
        r = x * b;
        c = (r > 255) ? 1 : 0;
        cyc = 10;
      end
    endcase
    r = r & 255;
    fl_o = ((r == 0) ? 8 : 0) + c * 4 + ((r >= 128) ? 2 : 0) + v;
    r_o  = (op == 15) ? prev : r;
  endfunction

  // Issue one op, optionally poke start while busy, then check result and latency.
  task automatic run_op(input int op, input int x, input int b, input int ci,
                        input bit poke);
    int er, ef, ec, k;
    model(op, x, b, ci, prev_dout, er, ef, ec);
    aif.alus  = 4'(op);
    aif.x     = 8'(x);
    aif.bus   = 8'(b);
    aif.cin   = 1'(ci);
    aif.start = 1'b1;
    @(posedge clk); #1;
    aif.start = 1'b0;
    aif.x     = 8'($urandom);
    aif.bus   = 8'($urandom);
    check("busy_after_accept", 32'(aif.busy), (ec > 1) ? 1 : 0);
    k = 1;
    while (!aif.done && k < 40) begin
      if (poke) begin
        aif.start = 1'($urandom);
        aif.alus  = 4'($urandom);
      end
      @(posedge clk); #1;
      k++;
    end
    aif.start = 1'b0;
    check("latency", 32'(k), 32'(ec));
    check("dout", 32'(aif.dout), 32'(er));
    check("flags", 32'(aif.flags), 32'(ef));
    check("busy_at_done", 32'(aif.busy), 0);
    @(posedge clk); #1;
    check("done_pulse", 32'(aif.done), 0);
    prev_dout = er;
  endtask

  int dir_op[9]  = '{0, 0, 2, 15, 9, 12, 13, 14, 14};
  int dir_x[9]   = '{'h7F, 'hFF, 'h03, 'h05, 'h10, 'h81, 'h5A, 'h0F, 'h10};
  int dir_b[9]   = '{'h01, 'h01, 'h05, 'h05, 'h0F, 3, 0, 'h11, 'h10};
  int dir_c[9]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    int er, ef, ec, dones;
    aif.start = 1'b0;
    aif.alus  = '0;
    aif.x     = '0;
    aif.bus   = '0;
    aif.cin   = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dout", 32'(aif.dout), 0);
    check("rst_flags", 32'(aif.flags), 0);
    check("rst_busy", 32'(aif.busy), 0);
    check("rst_done", 32'(aif.done), 0);

    for (int i = 0; i < 9; i++) run_op(dir_op[i], dir_x[i], dir_b[i], dir_c[i], (i == 5));

    // Back-to-back single-cycle ops with start held high.
    for (int i = 0; i < 40; i++) begin
      int op, x, b, ci;
      do op = int'($urandom_range(0, 15)); while (op >= 12 && op <= 14);
      x = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      ci = int'($urandom_range(0, 1));
      model(op, x, b, ci, prev_dout, er, ef, ec);
      aif.alus = 4'(op); aif.x = 8'(x); aif.bus = 8'(b); aif.cin = 1'(ci);
      aif.start = 1'b1;
      @(posedge clk); #1;
      check("b2b_done", 32'(aif.done), 1);
      check("b2b_dout", 32'(aif.dout), 32'(er));
      check("b2b_flags", 32'(aif.flags), 32'(ef));
      prev_dout = er;
    end
    aif.start = 1'b0;
    @(posedge clk); #1;

    // Random mix including multi-cycle ops and ignored starts while busy.
    for (int i = 0; i < 250; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1));

    // Reset during the fourth ITER cycle of a multiply.
    aif.alus = 4'hE; aif.x = 8'h0F; aif.bus = 8'h11; aif.start = 1'b1;
    @(posedge clk); #1;
    aif.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_busy_before_rst", 32'(aif.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_dout", 32'(aif.dout), 0);
    check("mid_rst_flags", 32'(aif.flags), 0);
    check("mid_rst_busy", 32'(aif.busy), 0);
    dones = 0;
    repeat (12) begin
      if (aif.done) dones++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_done", 32'(dones), 0);
    prev_dout = 0;
    run_op(0, 2, 3, 0, 1'b0);
    check("post_rst_add", 32'(aif.dout), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath's 8-bit combinational ALU. Operands are x (from Rs) and bus (from Rd); the result goes back to the register file / bus.
- Adds several things the combinational unit lacks: WIDTH generalisation, a 4-bit opcode space whose low half keeps the legacy 3-bit encoding, registered Z/C/N/V flags, carry-in ops, and multi-cycle ops (multi-bit shifts, multiply).
- Uses a start/busy/done handshake so the control unit can stall on multi-cycle ops.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the shift-count field taken from bus[CNT_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- alus  in  4  opcode.
- x  in  WIDTH  operand A (Rs).
- bus  in  WIDTH  operand B (Rd); also the shift count for SHLN/SHRN.
- cin  in  1  carry-in for ADC/SBB.
- dout  out  WIDTH  registered result.
- flags  out  4  registered {Z,C,N,V}, bit3..bit0.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when dout/flags update.

Behaviour:
- Reset: on rst=1 at a clock edge, dout=0, flags=0, busy=0, done=0, FSM=IDLE, internal counters and accumulators cleared. rst has priority over everything, including an op in flight; that op is abandoned and no done is issued.
- Opcodes, with op[3]=0 matching the legacy encoding:
  - 0000 ADD x+bus
  - 0001 INC x+1
  - 0010 SUB x-bus
  - 0011 DEC x-1
  - 0100 AND
  - 0101 OR
  - 0110 NOT ~x
  - 0111 SHL x<<1
  - 1000 ADC x+bus+cin
  - 1001 SBB x-bus-cin
  - 1010 XOR
  - 1011 SHR x>>1 (logical)
  - 1100 SHLN x<<n
  - 1101 SHRN x>>n (logical), with n = bus[CNT_W-1:0] clamped to WIDTH
  - 1110 MUL low WIDTH bits of x*bus (unsigned)
  - 1111 CMP: computes flags of x-bus; dout holds its previous value.
- FSM states: IDLE, ITER, FIN.
  - IDLE, start=1, single-cycle op (all except SHLN/SHRN/MUL): dout/flags written at that edge's result, done=1 in the next cycle, stay IDLE, busy stays 0. Latency is 1 cycle, and back-to-back starts give one result per cycle.
  - IDLE, start=1, SHLN/SHRN/MUL: latch operands and opcode, load counter (n for shifts, WIDTH for MUL), go to ITER, busy=1.
  - SHLN/SHRN with n=0: go directly to FIN.
  - ITER: shift one bit per cycle, or do one shift-add step per cycle for MUL, and decrement the counter. When the counter reaches 0, go to FIN.
  - FIN: write dout/flags, pulse done, clear busy, return to IDLE.
  - Totals: shifts take n+2 cycles from the start edge to done high; MUL takes WIDTH+2.
- start while busy=1 is ignored (no queueing). alus/x/bus/cin may change freely after accept.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C = unsigned carry-out for ADD/ADC/INC. For SUB/SBB/DEC/CMP, C is the borrow (1 when the minuend is less than the subtrahend plus borrow-in).
  - C for SHL/SHR = bit shifted out. C for SHLN/SHRN = last bit shifted out, 0 when n=0. C for MUL = 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero. C for logic ops = 0.
  - V = signed overflow for ADD/ADC/INC/SUB/SBB/DEC/CMP, 0 otherwise.
  - flags hold until the next done.
- Wrap-around is modulo 2^WIDTH. Counts >= WIDTH produce 0 after WIDTH iterations.

Decomposition:
- Package alu_pkg:
  - opcode localparams (ADD..CMP, 4-bit);
  - flag bit indices FZ=3, FC=2, FN=1, FV=0;
  - FSM state encodings.
- Sub-module alu_core: combinational single-cycle ops plus flag generation. Parameter WIDTH; inputs alus/x/bus/cin; outputs res/flags. alu_seq adds the FSM, the iterative shifter/multiplier and the output registers.

Test Plan (WIDTH=8):
- Reset/idle: rst held 2 cycles then released -> dout=0x00, flags=0000, busy=0, done=0.
- Carry and overflow:
  - ADD x=0x7F bus=0x01 -> next cycle dout=0x80, Z=0 C=0 N=1 V=1, done pulse 1 cycle.
  - ADD x=0xFF bus=0x01 -> dout=0x00, Z=1 C=1 N=0 V=0.
- Borrow and CMP:
  - SUB x=0x03 bus=0x05 -> dout=0xFE, C=1 N=1 V=0.
  - CMP x=0x05 bus=0x05 (previous dout=0xFE) -> dout stays 0xFE, Z=1 C=0.
  - SBB x=0x10 bus=0x0F cin=1 -> 0x00, Z=1.
- Multi-cycle shift:
  - SHLN x=0x81 bus=3 -> busy high, done exactly 5 cycles after the start edge, dout=0x08, C=0.
  - SHRN bus=0 -> done after 2 cycles, dout=x, C=0.
  - start pulsed while busy -> ignored.
- MUL:
  - x=0x0F bus=0x11 -> done 10 cycles after start, dout=0xFF, C=0.
  - x=0x10 bus=0x10 -> dout=0x00, Z=1 C=1.
- Reset mid-op: MUL started, rst asserted on the 4th ITER cycle -> outputs 0, busy=0, no done. A following ADD 0x02+0x03 -> 0x05.
